// File: rtl/hs4_sync_tx.sv
// Clocked head of a 4-phase bundled-data pipeline: a FIFO feeds data_out; each word gets a setup delay and then one req/ack cycle.
// Latency: a push into an idle, empty block reaches data_out 1 cycle later, and req_out rises SETUP_CYC cycles after that.
// Backpressure: in_ready drops when the FIFO is full; the watchdog exists only with HS4_TIMEOUT_EN.

module hs4_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_push_vld) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_vld) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (i_push_vld && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push_vld && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

module hs4_sync_tx #(
    parameter int WIDTH       = 3,
    parameter int DEPTH       = 4,
    parameter int SETUP_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req_out,
    input  logic             ack_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             timeout_err
);
    localparam int SCW = $clog2(SETUP_CYC + 1);
    localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_REQ_HI = 2'd2,
        S_REQ_LO = 2'd3
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SETUP_CYC < 1 ||
        SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("hs4_sync_tx: illegal parameter set");
    end

    state_t                 r_state;
    logic [SCW-1:0]         r_setup_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ack_s;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [WIDTH-1:0]       w_head;

    assign w_ack_s  = r_sync[SYNC_STAGES-1];
    assign in_ready = !rst && !w_full;
    assign w_push   = in_valid && in_ready;
    assign busy     = (r_state != S_IDLE) || !w_empty;

    // A new word is only launched once the async side has returned ack to zero.
    always_comb begin
        w_pop = 1'b0;
        if ((r_state == S_IDLE || r_state == S_REQ_LO) && !w_ack_s && !w_empty) begin
            w_pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    hs4_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (w_push),
        .i_push_dat (in_data),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            req_out     <= 1'b0;
            data_out    <= '0;
            r_setup_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        data_out    <= w_head;
                        r_setup_cnt <= '0;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_setup_cnt == SETUP_LAST) begin
                        req_out <= 1'b1;
                        r_state <= S_REQ_HI;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + SCW'(1);
                    end
                end
                S_REQ_HI: begin
                    if (w_ack_s) begin
                        req_out <= 1'b0;
                        r_state <= S_REQ_LO;
                    end
                end
                S_REQ_LO: begin
                    if (!w_ack_s) begin
                        if (w_pop) begin
                            data_out    <= w_head;
                            r_setup_cnt <= '0;
                            r_state     <= S_SETUP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    req_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef HS4_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCW-1:0] TO_LIMIT = TCW'(TIMEOUT_CYC);
    localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYC - 1);

    logic [TCW-1:0] r_to_cnt;
    logic           r_timeout_err;
    logic           w_in_hs;
    logic           w_leave;

    assign w_in_hs = (r_state == S_REQ_HI) || (r_state == S_REQ_LO);

    // Any transition taken this edge restarts the watchdog count.
    always_comb begin
        w_leave = 1'b0;
        case (r_state)
            S_SETUP:  w_leave = (r_setup_cnt == SETUP_LAST);
            S_REQ_HI: w_leave = w_ack_s;
            S_REQ_LO: w_leave = !w_ack_s;
            default:  w_leave = w_pop;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (!w_in_hs || w_leave) begin
            r_to_cnt <= '0;
        end else begin
            if (r_to_cnt != TO_LIMIT) begin
                r_to_cnt <= r_to_cnt + TCW'(1);
            end
            if (r_to_cnt == TO_LAST) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_hs4_sync_tx.sv
// Directed bench for hs4_sync_tx: latency, FIFO fill, back-to-back, reset mid-handshake, spurious ack, watchdog.
module tb_hs4_sync_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       req_out;
    logic       ack_in;
    logic [2:0] data_out;
    logic       busy;
    logic       timeout_err;

    int n_vec = 0;
    int n_err = 0;

    hs4_sync_tx #(
        .WIDTH       (3),
        .DEPTH       (4),
        .SETUP_CYC   (2),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .req_out     (req_out),
        .ack_in      (ack_in),
        .data_out    (data_out),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_req_hi(input string tag);
        int n = 0;
        while (!req_out && n < 40) begin
            tick();
            n++;
        end
        chk(tag, req_out, 1);
    endtask

    // Responder: ack 3 cycles after req rises, release ack 3 cycles after req falls.
    task automatic do_hs(input logic [2:0] w, input logic has_next, input logic [2:0] nxt);
        wait_req_hi("req_rise");
        chk("dat_at_req", data_out, w);
        repeat (3) begin
            tick();
            chk("dat_hold_hi", data_out, w);
            chk("req_hold_hi", req_out, 1);
        end
        ack_in = 1'b1;
        tick();
        tick();
        chk("req_before_sync", req_out, 1);
        tick();
        chk("req_fall", req_out, 0);
        chk("dat_hold_fall", data_out, w);
        repeat (3) tick();
        ack_in = 1'b0;
        tick();
        tick();
        chk("busy_req_lo", busy, 1);
        chk("dat_hold_lo", data_out, w);
        tick();
        if (has_next) begin
            chk("b2b_pop", data_out, nxt);
            chk("b2b_req_lo", req_out, 0);
            chk("b2b_busy", busy, 1);
            tick();
            chk("b2b_setup", req_out, 0);
            tick();
            chk("b2b_req_hi", req_out, 1);
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_dat", data_out, w);
        end
        chk("no_timeout", timeout_err, 0);
    endtask

    initial begin
        logic exp_to;
`ifdef HS4_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ack_in   = 1'b0;
        tick();
        tick();
        chk("rst_req", req_out, 0);
        chk("rst_dat", data_out, 0);
        chk("rst_to", timeout_err, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", in_ready, 1);

        // Single word latency
        push(3'b101);
        chk("lat_e0_dat", data_out, 0);
        chk("lat_e0_busy", busy, 1);
        tick();
        chk("lat_e1_dat", data_out, 3'b101);
        chk("lat_e1_req", req_out, 0);
        tick();
        chk("lat_e2_req", req_out, 0);
        tick();
        chk("lat_e3_req", req_out, 1);
        do_hs(3'b101, 1'b0, 3'b000);

        // Spurious ack in IDLE
        ack_in = 1'b1;
        repeat (4) begin
            tick();
            chk("spur_req", req_out, 0);
            chk("spur_dat", data_out, 3'b101);
            chk("spur_busy", busy, 0);
        end
        ack_in = 1'b0;
        repeat (3) tick();
        chk("spur_end_busy", busy, 0);

        // FIFO full
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) chk("rdy_before_w5", in_ready, 1);
            push(3'(i));
        end
        chk("full_rdy", in_ready, 0);
        chk("full_dat", data_out, 1);
        do_hs(3'd1, 1'b1, 3'd2);
        chk("rdy_after_pop", in_ready, 1);
        do_hs(3'd2, 1'b1, 3'd3);
        do_hs(3'd3, 1'b1, 3'd4);
        do_hs(3'd4, 1'b1, 3'd5);
        do_hs(3'd5, 1'b0, 3'd0);

        // Back-to-back with two words
        push(3'd6);
        push(3'd3);
        do_hs(3'd6, 1'b1, 3'd3);
        do_hs(3'd3, 1'b0, 3'd0);

        // Reset mid-handshake with ack held high
        push(3'd6);
        wait_req_hi("rmh_req");
        ack_in = 1'b1;
        rst    = 1'b1;
        tick();
        chk("rmh_req_drop", req_out, 0);
        chk("rmh_dat", data_out, 0);
        chk("rmh_rdy", in_ready, 0);
        rst = 1'b0;
        tick();
        tick();
        push(3'd7);
        repeat (2) begin
            tick();
            chk("rmh_hold_req", req_out, 0);
            chk("rmh_hold_dat", data_out, 0);
        end
        chk("rmh_busy", busy, 1);
        ack_in = 1'b0;
        tick();
        tick();
        chk("rmh_e2_dat", data_out, 0);
        tick();
        chk("rmh_e3_dat", data_out, 7);
        chk("rmh_e3_req", req_out, 0);
        tick();
        chk("rmh_e4_req", req_out, 0);
        tick();
        chk("rmh_e5_req", req_out, 1);
        do_hs(3'd7, 1'b0, 3'd0);

        // Watchdog: ack never arrives
        push(3'd2);
        wait_req_hi("to_req");
        repeat (7) begin
            tick();
            chk("to_early", timeout_err, 0);
        end
        tick();
        chk("to_flag", timeout_err, {31'd0, exp_to});
        chk("to_req_held", req_out, 1);
        tick();
        chk("to_sticky", timeout_err, {31'd0, exp_to});
        rst = 1'b1;
        tick();
        chk("to_rst_clear", timeout_err, 0);
        chk("to_rst_req", req_out, 0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
